// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Time-shares one external combinational 32-bit ALU between two requesters.
//   Requester 0 is the execute-stage datapath. Requester 1 is the
//   address/branch helper. The block arbitrates between the two requesters and
//   drives the ALU operand and opcode inputs from registers. It captures the
//   ALU result one cycle later and returns it to the winning requester over a
//   valid/ready response channel. Only one operation is in flight at a time,
//   so each operation takes at least 3 cycles: accept, execute, respond.
//
// Parameters:
//   RR_EN  1 = round-robin between requesters, 0 = fixed priority (req0 wins)
//   OP_W   width of the ALU opcode field
//
// Ports:
//   i_clk, i_rst            clock and synchronous active-high reset
//   i_reqX_valid/o_reqX_ready, i_reqX_operand_a/b, i_reqX_alu_op
//                           request channel of requester X (X = 0, 1)
//   o_rspX_valid/i_rspX_ready, o_rspX_data
//                           response channel of requester X
//   o_alu_operand_a/b, o_alu_op   registered drive to the external ALU
//   i_alu_data              combinational result from the external ALU
//   o_busy                  high whenever the FSM is not in IDLE
//
// Handshake semantics (all four channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A request is accepted only in IDLE, and only the arbitration winner sees
//   ready. Ready never depends on anything but state, arbitration and the
//   reset. The response stays valid with stable data until the matching ready
//   arrives. A requester may lower valid at any time before acceptance; that
//   request then simply never happened.
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int RR_EN = 1,
  parameter int OP_W  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [31:0]     i_req0_operand_a,
  input  logic [31:0]     i_req0_operand_b,
  input  logic [OP_W-1:0] i_req0_alu_op,
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  output logic [31:0]     o_rsp0_data,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [31:0]     i_req1_operand_a,
  input  logic [31:0]     i_req1_operand_b,
  input  logic [OP_W-1:0] i_req1_alu_op,
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  output logic [31:0]     o_rsp1_data,

  output logic [31:0]     o_alu_operand_a,
  output logic [31:0]     o_alu_operand_b,
  output logic [OP_W-1:0] o_alu_op,
  input  logic [31:0]     i_alu_data,

  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // id of the last completed op
  logic              grant_q, grant_d;            // id of the op in flight
  logic [31:0]       alu_a_q, alu_a_d;
  logic [31:0]       alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [31:0]       result_q, result_d;

  // Arbitration winner: 1 = requester 1 wins, 0 = requester 0 wins.
  logic              win1;

  always_comb begin
    win1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      // On a tie, round-robin favours whichever side did not complete last.
      // Because last_grant resets to 1, req0 wins the first tie.
      if (RR_EN != 0) begin
        win1 = (last_grant_q == 1'b0);
      end else begin
        win1 = 1'b0;
      end
    end else begin
      win1 = i_req1_valid;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
    end
  end

  // Next state and outputs
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;

    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp0_valid = 1'b0;
    o_rsp1_valid = 1'b0;
    o_rsp0_data  = 32'd0;
    o_rsp1_data  = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        // Ready is suppressed during reset so nothing is seen as accepted
        // in a cycle whose state update is discarded anyway.
        if (!i_rst) begin
          o_req0_ready = i_req0_valid && !win1;
          o_req1_ready = i_req1_valid &&  win1;
          if (i_req0_valid || i_req1_valid) begin
            grant_d = win1;
            if (win1) begin
              alu_a_d  = i_req1_operand_a;
              alu_b_d  = i_req1_operand_b;
              alu_op_d = i_req1_alu_op;
            end else begin
              alu_a_d  = i_req0_operand_a;
              alu_b_d  = i_req0_operand_b;
              alu_op_d = i_req0_alu_op;
            end
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        // The ALU sees the registered operands for this whole cycle.
        result_d = i_alu_data;
        state_d  = S_RESP;
      end

      S_RESP: begin
        if (grant_q) begin
          o_rsp1_valid = 1'b1;
          o_rsp1_data  = result_q;
          if (i_rsp1_ready) begin
            last_grant_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else begin
          o_rsp0_valid = 1'b1;
          o_rsp0_data  = result_q;
          if (i_rsp0_ready) begin
            last_grant_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_alu_operand_a = alu_a_q;
  assign o_alu_operand_b = alu_b_q;
  assign o_alu_op        = alu_op_q;
  assign o_busy          = (state_q != S_IDLE);

endmodule
